// File: rtl/dma_uart_pkg.sv
// Shared constants, FSM state type and packet byte selection for the DMA-to-UART bridge.
package dma_uart_pkg;

    localparam int       DEFAULT_CLKS_PER_BIT = 5208;  // 9600 baud at 50 MHz
    localparam int       PKT_BYTES            = 4;
    localparam int       BITS_PER_FRAME       = 10;    // start + 8 data + stop
    localparam logic     CMD_WRITE            = 1'b1;  // byte0 bit 7

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    // Packet register layout is {addr[6:0], dat[17:0]}.
    function automatic logic [7:0] pkt_byte(input logic [24:0] pkt, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = {CMD_WRITE, pkt[24:18]};
            2'd1:    b = pkt[7:0];
            2'd2:    b = pkt[15:8];
            default: b = {6'b000000, pkt[17:16]};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dma_uart_port_uart_tx.sv
// 8N1 byte serializer. busy drops during the final cycle of the stop bit so a
// follower byte can be accepted on the edge that ends it, giving no idle gap.
module uart_tx
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       en,
    output logic       busy,
    output logic       txd
);

    localparam int         CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'(BITS_PER_FRAME - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sending;
    logic          bit_end;
    logic          last_cycle;
    logic          accept;

    assign bit_end    = sending && (cnt == CNT_MAX);
    assign last_cycle = bit_end && (bit_idx == STOP_IDX);
    assign busy       = sending && !last_cycle;
    assign accept     = en && !busy;

    // Bit timing, bit index and data shift register; a new byte takes priority over finishing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= 4'd0;
            shreg   <= 8'h00;
            sending <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            bit_idx <= 4'd0;
            shreg   <= data;
            sending <= 1'b1;
        end else if (sending) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == STOP_IDX) begin
                    sending <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
                if ((bit_idx >= 4'd1) && (bit_idx <= 4'd8)) begin
                    shreg <= {1'b0, shreg[7:1]};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Line level: start bit low, data LSB first, stop bit and idle high.
    always_comb begin
        txd = 1'b1;
        if (sending) begin
            if (bit_idx == 4'd0) begin
                txd = 1'b0;
            end else if (bit_idx == STOP_IDX) begin
                txd = 1'b1;
            end else begin
                txd = shreg[0];
            end
        end
    end

endmodule

// File: rtl/dma_uart_port.sv
// DMA write bridge: latches one register write and sends it as a 4-byte 8N1 packet.
module dma_uart_port
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] dma_dat_w,
    input  logic [6:0]  dma_dat_addr,
    input  logic        we,
    output logic        busy,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [1:0] LAST_BYTE = 2'(PKT_BYTES - 1);

    state_t      state;
    state_t      next_state;
    logic [24:0] pkt;
    logic [1:0]  byte_idx;
    logic        load_pkt;
    logic        tx_en;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        rxd_unused;

    // Receive path is reserved in this revision.
    assign rxd_unused = uart_rxd;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state; a write landing on the final stop-bit edge starts the next packet directly.
    always_comb begin
        next_state = state;
        load_pkt   = 1'b0;
        case (state)
            IDLE: begin
                if (we) begin
                    next_state = LOAD;
                    load_pkt   = 1'b1;
                end
            end
            LOAD: next_state = SEND;
            SEND: begin
                if (!tx_busy && (byte_idx == LAST_BYTE)) begin
                    if (we) begin
                        next_state = LOAD;
                        load_pkt   = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: busy from state, serializer feed for byte0 in LOAD and followers in SEND.
    always_comb begin
        busy    = (state != IDLE);
        tx_en   = 1'b0;
        tx_data = 8'h00;
        case (state)
            LOAD: begin
                tx_en   = 1'b1;
                tx_data = pkt_byte(pkt, 2'd0);
            end
            SEND: begin
                if (!tx_busy && (byte_idx != LAST_BYTE)) begin
                    tx_en   = 1'b1;
                    tx_data = pkt_byte(pkt, byte_idx + 2'd1);
                end
            end
            default: ;
        endcase
    end

    // Packet register and byte sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt      <= '0;
            byte_idx <= 2'd0;
        end else if (load_pkt) begin
            pkt      <= {dma_dat_addr, dma_dat_w};
            byte_idx <= 2'd0;
        end else if ((state == SEND) && tx_en) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .en    (tx_en),
        .busy  (tx_busy),
        .txd   (uart_txd)
    );

endmodule

// File: tb/tb_dma_uart_port.sv
// Directed bench for dma_uart_port with a short bit period.
module tb_dma_uart_port;

    localparam int C = 16;

    logic        clk;
    logic        reset;
    logic [17:0] dma_dat_w;
    logic [6:0]  dma_dat_addr;
    logic        we;
    logic        busy;
    logic        uart_rxd;
    logic        uart_txd;

    int n_cmp = 0;
    int n_mis = 0;

    dma_uart_port #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .dma_dat_w    (dma_dat_w),
        .dma_dat_addr (dma_dat_addr),
        .we           (we),
        .busy         (busy),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the acceptance edge.
    task automatic start_packet(input logic [17:0] dat, input logic [6:0] addr);
        dma_dat_w    = dat;
        dma_dat_addr = addr;
        we           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we           = 1'b0;
        dma_dat_w    = ~dat;
        dma_dat_addr = ~addr;
    endtask

    // Starts at the negedge half a cycle after acceptance and checks every bit mid-period.
    task automatic check_packet(input string tag,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input bit inject, input bit b2b,
                                input logic [17:0] nd, input logic [6:0] na);
        logic [7:0] bytes [4];
        logic [7:0] bv;
        logic       expb;
        int         pos;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        chk({tag, " busy_after_accept"}, {7'd0, busy}, 8'd1);
        chk({tag, " txd_load_cycle"}, {7'd0, uart_txd}, 8'd1);
        @(negedge clk);
        chk({tag, " start_edge"}, {7'd0, uart_txd}, 8'd0);
        repeat (C / 2) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            bv  = bytes[k / 10];
            pos = k % 10;
            if (pos == 0)      expb = 1'b0;
            else if (pos == 9) expb = 1'b1;
            else               expb = bv[pos - 1];
            chk($sformatf("%s bit%0d", tag, k), {7'd0, uart_txd}, {7'd0, expb});
            if (inject && k == 15) begin
                dma_dat_w    = 18'h2AAAA;
                dma_dat_addr = 7'h55;
                we           = 1'b1;
            end
            if (k < 39) begin
                repeat (C) begin
                    @(negedge clk);
                    we = 1'b0;
                end
            end
        end
        repeat (C / 2 - 1) @(negedge clk);
        chk({tag, " busy_last_cycle"}, {7'd0, busy}, 8'd1);
        if (b2b) begin
            dma_dat_w    = nd;
            dma_dat_addr = na;
            we           = 1'b1;
            @(posedge clk);
            @(negedge clk);
            we           = 1'b0;
            dma_dat_w    = ~nd;
            dma_dat_addr = ~na;
        end else begin
            @(negedge clk);
            chk({tag, " busy_fall"}, {7'd0, busy}, 8'd0);
            chk({tag, " txd_idle"}, {7'd0, uart_txd}, 8'd1);
            repeat (2 * C) @(negedge clk);
            chk({tag, " busy_quiet"}, {7'd0, busy}, 8'd0);
            chk({tag, " txd_quiet"}, {7'd0, uart_txd}, 8'd1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        we           = 1'b0;
        dma_dat_w    = 18'd0;
        dma_dat_addr = 7'd0;
        uart_rxd     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset txd", {7'd0, uart_txd}, 8'd1);

        // Single write with a rejected mid-packet write.
        start_packet(18'b010101010101010101, 7'b0011001);
        check_packet("single", 8'h99, 8'h55, 8'h55, 8'h01, 1'b1, 1'b0, 18'd0, 7'd0);

        // Back-to-back: second write on the edge where busy would fall.
        start_packet(18'h12345, 7'h2A);
        check_packet("b2b_first", 8'hAA, 8'h45, 8'h23, 8'h01, 1'b0, 1'b1, 18'h0BEEF, 7'h11);
        check_packet("b2b_second", 8'h91, 8'hEF, 8'hBE, 8'h00, 1'b0, 1'b0, 18'd0, 7'd0);

        // Boundary data.
        start_packet(18'h3FFFF, 7'h7F);
        check_packet("all_ones", 8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0, 1'b0, 18'd0, 7'd0);
        start_packet(18'h00000, 7'h00);
        check_packet("all_zero", 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 18'd0, 7'd0);

        // Asynchronous reset in the middle of byte2 (packet bit 25 = byte2 data bit 4).
        start_packet(18'h3A5C3, 7'h05);
        repeat (1 + 25 * C + C / 2) @(negedge clk);
        chk("abort mid_byte2 txd", {7'd0, uart_txd}, 8'd0);
        #2 reset = 1'b1;
        #1;
        chk("abort txd_async", {7'd0, uart_txd}, 8'd1);
        chk("abort busy_async", {7'd0, busy}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * C) @(negedge clk);
        chk("abort txd_after", {7'd0, uart_txd}, 8'd1);
        chk("abort busy_after", {7'd0, busy}, 8'd0);

        start_packet(18'h2C81E, 7'h3C);
        check_packet("fresh", 8'hBC, 8'h1E, 8'hC8, 8'h02, 1'b0, 1'b0, 18'd0, 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
